// File: rtl/Global.sv
// Core-wide shared types; the machine word is 32 bits (RV32I).
package Global;
  typedef logic [31:0] size_t;
endpackage

// File: rtl/IF.sv
// Types and constants shared by the instruction-fetch stage and its users (IR, debug unit).
package IF;
  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_WAIT, ST_DRAIN} state_t;
  typedef enum logic [1:0] {FAULT_NONE, FAULT_MISALIGNED, FAULT_TIMEOUT} fault_t;

  localparam Global::size_t NOP         = 32'h0000_0013;
  localparam int unsigned   INSTR_BYTES = 4;
endpackage

// File: rtl/pc_reg.sv
// PC register: a redirect load has priority over a sequential step of base+INSTR_BYTES.
// One-cycle update, no backpressure; the increment wraps modulo 2^32.
module pc_reg
  import IF::*;
#(
  parameter Global::size_t RESET_PC = 32'h0000_0000
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we_i,
  input  Global::size_t wdata_i,
  input  logic          inc_i,
  input  Global::size_t base_i,
  output Global::size_t pc_o
);
  Global::size_t pc_q, pc_d;

  always_comb begin
    pc_d = pc_q;
    if (we_i)       pc_d = wdata_i;
    else if (inc_i) pc_d = base_i + Global::size_t'(INSTR_BYTES);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pc_q <= RESET_PC;
    else     pc_q <= pc_d;
  end

  assign pc_o = pc_q;
endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: one memory read per fetch_req, fetch_done 3 cycles later at best.
// Request is held until mem_gnt; redirects abort or drain the transaction.
module fetch_unit
  import IF::*;
#(
  parameter Global::size_t RESET_PC   = 32'h0000_0000,
  parameter int unsigned   WAIT_LIMIT = 255
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          fetch_req,
  input  logic          pc_we,
  input  Global::size_t pc_in,
  output Global::size_t pc,
  output Global::size_t fetch_pc,
  output Global::size_t instr,
  output logic          fetch_done,
  output logic          busy,
  output logic          fault_valid,
  output fault_t        fault_cause,
  output logic          mem_req,
  output Global::size_t mem_addr,
  input  logic          mem_gnt,
  input  logic          mem_rvalid,
  input  Global::size_t mem_rdata
);
  state_t        state_q, state_d;
  Global::size_t req_addr_q, req_addr_d;
  Global::size_t fetch_pc_q, fetch_pc_d;
  Global::size_t instr_q, instr_d;
  logic          done_q, done_d;
  logic          fault_q, fault_d;
  fault_t        cause_q, cause_d;
  logic [31:0]   cnt_q, cnt_d;
  logic          pc_inc;
  Global::size_t fetch_addr;

  // A redirect in the same cycle as fetch_req is the address that gets fetched.
  assign fetch_addr = pc_we ? pc_in : pc;

  pc_reg #(.RESET_PC(RESET_PC)) u_pc_reg (
    .clk     (clk),
    .rst     (rst),
    .we_i    (pc_we),
    .wdata_i (pc_in),
    .inc_i   (pc_inc),
    .base_i  (req_addr_q),
    .pc_o    (pc)
  );

  always_comb begin
    state_d    = state_q;
    req_addr_d = req_addr_q;
    fetch_pc_d = fetch_pc_q;
    instr_d    = instr_q;
    done_d     = 1'b0;
    fault_d    = 1'b0;
    cause_d    = cause_q;
    cnt_d      = cnt_q;
    pc_inc     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (fetch_req) begin
          if (fetch_addr[1:0] != 2'b00) begin
            fault_d = 1'b1;
            cause_d = FAULT_MISALIGNED;
          end else begin
            req_addr_d = fetch_addr;
            state_d    = ST_REQ;
          end
        end
      end
      ST_REQ: begin
        if (pc_we) begin
          state_d = ST_IDLE;
        end else if (mem_gnt) begin
          state_d = ST_WAIT;
          cnt_d   = '0;
        end
      end
      ST_WAIT: begin
        if (mem_rvalid && !pc_we) begin
          instr_d    = mem_rdata;
          fetch_pc_d = req_addr_q;
          pc_inc     = 1'b1;
          done_d     = 1'b1;
          state_d    = ST_IDLE;
        end else if (mem_rvalid) begin
          state_d = ST_IDLE;
        end else if (pc_we) begin
          state_d = ST_DRAIN;
        end else begin
          cnt_d = cnt_q + 32'd1;
          if ((WAIT_LIMIT != 0) && (cnt_d == WAIT_LIMIT)) begin
            fault_d = 1'b1;
            cause_d = FAULT_TIMEOUT;
            state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (mem_rvalid) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      req_addr_q <= RESET_PC;
      fetch_pc_q <= RESET_PC;
      instr_q    <= NOP;
      done_q     <= 1'b0;
      fault_q    <= 1'b0;
      cause_q    <= FAULT_NONE;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      req_addr_q <= req_addr_d;
      fetch_pc_q <= fetch_pc_d;
      instr_q    <= instr_d;
      done_q     <= done_d;
      fault_q    <= fault_d;
      cause_q    <= cause_d;
      cnt_q      <= cnt_d;
    end
  end

  assign fetch_pc    = fetch_pc_q;
  assign instr       = instr_q;
  assign fetch_done  = done_q;
  assign fault_valid = fault_q;
  assign fault_cause = cause_q;
  assign busy        = (state_q != ST_IDLE);
  assign mem_req     = (state_q == ST_REQ);
  assign mem_addr    = req_addr_q;
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with WAIT_LIMIT=4; inputs driven 1ns after posedge, outputs sampled there too.
module tb_fetch_unit;
  logic          clk = 1'b0;
  logic          rst;
  logic          fetch_req, pc_we, mem_gnt, mem_rvalid;
  Global::size_t pc_in, mem_rdata;
  Global::size_t pc, fetch_pc, instr, mem_addr;
  logic          fetch_done, busy, fault_valid, mem_req;
  IF::fault_t    fault_cause;

  int n_cmp = 0;
  int n_err = 0;

  fetch_unit #(.RESET_PC(32'h0000_0000), .WAIT_LIMIT(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .fetch_req   (fetch_req),
    .pc_we       (pc_we),
    .pc_in       (pc_in),
    .pc          (pc),
    .fetch_pc    (fetch_pc),
    .instr       (instr),
    .fetch_done  (fetch_done),
    .busy        (busy),
    .fault_valid (fault_valid),
    .fault_cause (fault_cause),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_gnt     (mem_gnt),
    .mem_rvalid  (mem_rvalid),
    .mem_rdata   (mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; fetch_req = 1'b0; pc_we = 1'b0; pc_in = '0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    #1;
    check("rst_pc", pc, 32'h0);
    check("rst_fetch_pc", fetch_pc, 32'h0);
    check("rst_instr", instr, 32'h0000_0013);
    check("rst_done", {31'b0, fetch_done}, 32'h0);
    check("rst_busy", {31'b0, busy}, 32'h0);
    check("rst_fault", {31'b0, fault_valid}, 32'h0);
    check("rst_cause", 32'(fault_cause), 32'h0);
    check("rst_req", {31'b0, mem_req}, 32'h0);
    tick(); tick();
    rst = 1'b0;

    // Basic fetch: immediate grant, rvalid one cycle later
    tick();
    fetch_req = 1'b1;
    tick();
    check("t1_req", {31'b0, mem_req}, 32'h1);
    check("t1_addr", mem_addr, 32'h0);
    check("t1_busy", {31'b0, busy}, 32'h1);
    fetch_req = 1'b0; mem_gnt = 1'b1;
    tick();
    check("t1_done_early", {31'b0, fetch_done}, 32'h0);
    mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h0050_0093;
    tick();
    check("t1_done", {31'b0, fetch_done}, 32'h1);
    check("t1_instr", instr, 32'h0050_0093);
    check("t1_fetch_pc", fetch_pc, 32'h0);
    check("t1_pc", pc, 32'h4);
    mem_rvalid = 1'b0;
    tick();
    check("t1_done_1cyc", {31'b0, fetch_done}, 32'h0);

    // Grant withheld for 5 cycles, then rvalid on the 4th WAIT cycle
    fetch_req = 1'b1;
    tick();
    fetch_req = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("t2_req_hold", {31'b0, mem_req}, 32'h1);
      check("t2_addr_hold", mem_addr, 32'h4);
      check("t2_no_done", {31'b0, fetch_done}, 32'h0);
      tick();
    end
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t2_no_timeout", {31'b0, fault_valid}, 32'h0);
      check("t2_wait_busy", {31'b0, busy}, 32'h1);
    end
    mem_rvalid = 1'b1; mem_rdata = 32'h00a0_0113;
    tick();
    mem_rvalid = 1'b0;
    check("t2_done", {31'b0, fetch_done}, 32'h1);
    check("t2_instr", instr, 32'h00a0_0113);
    check("t2_fetch_pc", fetch_pc, 32'h4);
    check("t2_pc", pc, 32'h8);

    // Redirect in WAIT, response arrives two cycles later and is dropped
    fetch_req = 1'b1;
    tick();
    fetch_req = 1'b0; mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0; pc_we = 1'b1; pc_in = 32'h0000_0100;
    tick();
    pc_we = 1'b0;
    check("t3_pc_redirect", pc, 32'h100);
    check("t3_drain_busy", {31'b0, busy}, 32'h1);
    tick();
    mem_rvalid = 1'b1; mem_rdata = 32'hdead_beef;
    tick();
    mem_rvalid = 1'b0;
    check("t3_no_done", {31'b0, fetch_done}, 32'h0);
    check("t3_instr_kept", instr, 32'h00a0_0113);
    check("t3_fetch_pc_kept", fetch_pc, 32'h4);
    check("t3_idle", {31'b0, busy}, 32'h0);
    fetch_req = 1'b1;
    tick();
    fetch_req = 1'b0;
    check("t3_new_addr", mem_addr, 32'h100);
    check("t3_new_req", {31'b0, mem_req}, 32'h1);
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h0000_0033;
    tick();
    mem_rvalid = 1'b0;
    check("t3_done", {31'b0, fetch_done}, 32'h1);
    check("t3_fetch_pc", fetch_pc, 32'h100);
    check("t3_pc", pc, 32'h104);

    // Redirect coinciding with rvalid: response discarded, straight to IDLE
    fetch_req = 1'b1;
    tick();
    fetch_req = 1'b0; mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0; pc_we = 1'b1; pc_in = 32'h0000_0200; mem_rvalid = 1'b1; mem_rdata = 32'h1234_5678;
    tick();
    pc_we = 1'b0; mem_rvalid = 1'b0;
    check("t3b_no_done", {31'b0, fetch_done}, 32'h0);
    check("t3b_idle", {31'b0, busy}, 32'h0);
    check("t3b_pc", pc, 32'h200);
    check("t3b_instr_kept", instr, 32'h0000_0033);

    // Misaligned target
    pc_we = 1'b1; pc_in = 32'h0000_0102;
    tick();
    pc_we = 1'b0;
    check("t4_pc_misaligned", pc, 32'h102);
    fetch_req = 1'b1;
    tick();
    fetch_req = 1'b0;
    check("t4_fault", {31'b0, fault_valid}, 32'h1);
    check("t4_cause", 32'(fault_cause), 32'h1);
    check("t4_no_req", {31'b0, mem_req}, 32'h0);
    check("t4_idle", {31'b0, busy}, 32'h0);
    tick();
    check("t4_fault_1cyc", {31'b0, fault_valid}, 32'h0);
    check("t4_cause_held", 32'(fault_cause), 32'h1);
    check("t4_no_req2", {31'b0, mem_req}, 32'h0);

    // Timeout after 4 WAIT cycles, late rvalid drained
    pc_we = 1'b1; pc_in = 32'h0000_0300;
    tick();
    pc_we = 1'b0; fetch_req = 1'b1;
    tick();
    fetch_req = 1'b0; mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t5_no_fault_yet", {31'b0, fault_valid}, 32'h0);
    end
    tick();
    check("t5_timeout", {31'b0, fault_valid}, 32'h1);
    check("t5_cause", 32'(fault_cause), 32'h2);
    check("t5_no_done", {31'b0, fetch_done}, 32'h0);
    tick();
    check("t5_fault_1cyc", {31'b0, fault_valid}, 32'h0);
    check("t5_drain_busy", {31'b0, busy}, 32'h1);
    mem_rvalid = 1'b1; mem_rdata = 32'h1111_1111;
    tick();
    mem_rvalid = 1'b0;
    check("t5_drain_done", {31'b0, fetch_done}, 32'h0);
    check("t5_idle", {31'b0, busy}, 32'h0);
    check("t5_instr_kept", instr, 32'h0000_0033);

    // Redirect before grant withdraws the request
    fetch_req = 1'b1;
    tick();
    fetch_req = 1'b0; pc_we = 1'b1; pc_in = 32'h0000_0400;
    tick();
    pc_we = 1'b0;
    check("t5b_withdrawn", {31'b0, mem_req}, 32'h0);
    check("t5b_idle", {31'b0, busy}, 32'h0);
    check("t5b_pc", pc, 32'h400);

    // PC wrap at the top of the address space
    pc_we = 1'b1; pc_in = 32'hFFFF_FFFC;
    tick();
    pc_we = 1'b0; fetch_req = 1'b1;
    tick();
    fetch_req = 1'b0;
    check("t6_addr_top", mem_addr, 32'hFFFF_FFFC);
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h0010_0073;
    tick();
    mem_rvalid = 1'b0;
    check("t6_done", {31'b0, fetch_done}, 32'h1);
    check("t6_pc_wrap", pc, 32'h0);
    check("t6_fetch_pc", fetch_pc, 32'hFFFF_FFFC);

    // Async reset in the middle of WAIT, then a stale rvalid
    fetch_req = 1'b1;
    tick();
    fetch_req = 1'b0; mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    check("t7_in_wait", {31'b0, busy}, 32'h1);
    #2 rst = 1'b1;
    #1;
    check("t7_rst_busy", {31'b0, busy}, 32'h0);
    check("t7_rst_req", {31'b0, mem_req}, 32'h0);
    check("t7_rst_instr", instr, 32'h0000_0013);
    check("t7_rst_fetch_pc", fetch_pc, 32'h0);
    check("t7_rst_cause", 32'(fault_cause), 32'h0);
    check("t7_rst_pc", pc, 32'h0);
    tick();
    rst = 1'b0;
    mem_rvalid = 1'b1; mem_rdata = 32'h0000_0099;
    tick();
    mem_rvalid = 1'b0;
    check("t7_stale_done", {31'b0, fetch_done}, 32'h0);
    check("t7_stale_instr", instr, 32'h0000_0013);
    check("t7_stale_idle", {31'b0, busy}, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
